// File: rtl/ifu_axi_fetch_if.sv
// AXI-Lite read channel bundle between the fetch unit (master)
// and the instruction memory (slave).
interface ifu_axi_fetch_if;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_araddr,
    output m_arvalid,
    input  m_arready,
    input  m_rdata,
    input  m_rresp,
    input  m_rvalid,
    output m_rready
  );

  modport slave (
    input  m_araddr,
    input  m_arvalid,
    output m_arready,
    output m_rdata,
    output m_rresp,
    output m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Single-outstanding instruction fetch over AXI-Lite with
// local misalignment faulting and redirect (flush) handling.
module ifu_axi_fetch #(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_valid,
  input  logic [31:0]      pc,
  output logic             pc_ready,
  input  logic             flush,
  ifu_axi_fetch_if.master  m,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    OUT,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        kill;
  logic        kill_nx;
  logic [31:0] addr_q;
  logic        accept;
  logic        r_take;
  logic        misal;

  assign misal = ALIGN_CHECK && (pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_nx;
      kill  <= kill_nx;
    end
  end

  // A killed read must still finish its R beat, so flush
  // only reroutes through DRAIN once the address is taken.
  always_comb begin
    state_nx = state;
    kill_nx  = kill;
    pc_ready = 1'b0;
    accept   = 1'b0;
    r_take   = 1'b0;
    unique case (state)
      IDLE: begin
        pc_ready = !flush;
        if (pc_valid && !flush) begin
          accept   = 1'b1;
          state_nx = misal ? OUT : AR;
        end
      end
      AR: begin
        if (flush)
          kill_nx = 1'b1;
        if (m.m_arready)
          state_nx = (kill || flush) ? DRAIN : R;
      end
      R: begin
        if (flush) begin
          state_nx = m.m_rvalid ? IDLE : DRAIN;
        end else if (m.m_rvalid) begin
          r_take   = 1'b1;
          state_nx = OUT;
        end
      end
      OUT: begin
        if (inst_ready || flush)
          state_nx = IDLE;
      end
      DRAIN: begin
        if (m.m_rvalid) begin
          kill_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      inst     <= '0;
      inst_pc  <= '0;
      inst_err <= 1'b0;
    end else begin
      if (accept && misal) begin
        inst     <= '0;
        inst_pc  <= pc;
        inst_err <= 1'b1;
      end else if (accept) begin
        addr_q <= pc;
      end
      if (r_take) begin
        inst     <= m.m_rdata;
        inst_pc  <= addr_q;
        inst_err <= (m.m_rresp != 2'b00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fetch_cnt <= '0;
    else if (inst_valid && inst_ready)
      fetch_cnt <= fetch_cnt + CNT_W'(1);
  end

  assign m.m_araddr  = addr_q;
  assign m.m_arvalid = (state == AR);
  assign m.m_rready  = (state == R) || (state == DRAIN);
  assign inst_valid  = (state == OUT);

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Scoreboard bench for ifu_axi_fetch: directed fetches against
// a delay-programmable AXI-Lite slave model.
module tb_ifu_axi_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc;
  logic        pc_ready;
  logic        flush;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] fetch_cnt;

  ifu_axi_fetch_if bus();

  ifu_axi_fetch #(
    .ALIGN_CHECK(1'b1),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_valid(pc_valid),
    .pc(pc),
    .pc_ready(pc_ready),
    .flush(flush),
    .m(bus),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_err(inst_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];

  int          ar_delay = 0;
  int          r_delay = 0;
  logic [31:0] sl_rdata = '0;
  logic [1:0]  sl_rresp = '0;
  bit          sl_auto = 1'b0;
  int          ph = 0;
  int          w = 0;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  logic [31:0] a_addr = '0;

  logic [31:0] b2b_exp [8] = '{
    32'h00000093, 32'h00400093,
    32'h00800093, 32'h00C00093,
    32'h01000093, 32'h01400093,
    32'h01800093, 32'h01C00093
  };

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic chk_eq(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] req);
    chk(act === req, nm, act, req);
  endtask

  task give;
    chk_eq("rready_on_beat", 32'(bus.m_rready), 32'd1);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = sl_auto ? {a_addr[11:0], 20'h00093} : sl_rdata;
    bus.m_rresp  = sl_auto ? 2'b00 : sl_rresp;
  endtask

  // Slave model: changes only at negedge, one beat per address.
  initial begin
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = '0;
    forever begin
      @(negedge clk);
      bus.m_arready = 1'b0;
      bus.m_rvalid  = 1'b0;
      if (rst) begin
        ph = 0;
        continue;
      end
      case (ph)
        1: begin
          chk_eq("ar_valid_hold", 32'(bus.m_arvalid), 32'd1);
          chk_eq("ar_addr_hold", bus.m_araddr, a_addr);
          w++;
          if (w >= ar_delay) begin
            bus.m_arready = 1'b1;
            ph = 2;
          end
        end
        2: begin
          ar_cnt++;
          w = 0;
          if (r_delay == 0) begin
            give();
            ph = 3;
          end else begin
            ph = 4;
          end
        end
        4: begin
          w++;
          if (w >= r_delay) begin
            give();
            ph = 3;
          end
        end
        3: begin
          r_cnt++;
          ph = 0;
        end
        default: ;
      endcase
      if (ph == 0 && bus.m_arvalid) begin
        a_addr = bus.m_araddr;
        w = 0;
        if (ar_delay == 0) begin
          bus.m_arready = 1'b1;
          ph = 2;
        end else begin
          ph = 1;
        end
      end
    end
  end

  exp_t        e;
  bit          seen = 1'b0;
  logic [31:0] h_inst;
  logic [31:0] h_pc;
  logic        h_err;

  // Monitor: pops the scoreboard on every delivered instruction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        continue;
      end
      if (inst_valid) begin
        chk_eq("no_ar_in_out", 32'(bus.m_arvalid), 32'd0);
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_inst", inst_pc, 32'd0);
        end else begin
          e = q[0];
          if (!seen) begin
            seen   = 1'b1;
            h_inst = inst;
            h_pc   = inst_pc;
            h_err  = inst_err;
            if (e.lat >= 0)
              chk_eq("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          end else begin
            chk_eq("hold_inst", inst, h_inst);
            chk_eq("hold_pc", inst_pc, h_pc);
            chk_eq("hold_err", 32'(inst_err), 32'(h_err));
          end
          if (inst_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
            chk_eq("inst", inst, e.inst);
            chk_eq("inst_pc", inst_pc, e.pc);
            chk_eq("inst_err", 32'(inst_err), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    pc_valid = 1'b0;
    flush = 1'b0;
    inst_ready = 1'b1;
    pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk_eq("rst_arvalid", 32'(bus.m_arvalid), 32'd0);
    chk_eq("rst_rready", 32'(bus.m_rready), 32'd0);
    chk_eq("rst_inst", inst, 32'd0);
    chk_eq("rst_inst_pc", inst_pc, 32'd0);
    chk_eq("rst_inst_err", 32'(inst_err), 32'd0);
    chk_eq("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk_eq("rst_araddr", bus.m_araddr, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("idle_pc_ready", 32'(pc_ready), 32'd1);
  endtask

  task automatic issue(input logic [31:0] a, input bit push,
                       input logic [31:0] ei, input logic ee,
                       input int lat);
    exp_t x;
    int n;
    n = 0;
    if (push) begin
      x.inst = ei;
      x.pc   = a;
      x.err  = ee;
      x.lat  = lat;
      q.push_back(x);
    end
    pc = a;
    pc_valid = 1'b1;
    @(negedge clk);
    while (!pc_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!pc_ready) begin
      chk(1'b0, "accept_timeout", a, 32'd0);
      pc_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    pc_valid = 1'b0;
  endtask

  task automatic settle;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q.size() == 0 && !inst_valid &&
                 !bus.m_arvalid && !bus.m_rready &&
                 pc_ready) && n < 400);
    chk(n < 400, "settle_timeout", 32'(n), 32'd400);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    pc_valid = 1'b0;
    pc = '0;
    flush = 1'b0;
    inst_ready = 1'b1;
    do_reset();

    sl_rdata = 32'h00000413;
    sl_rresp = 2'b00;
    issue(32'h80000000, 1, 32'h00000413, 1'b0, 2);
    settle();
    chk_eq("cnt_basic", fetch_cnt, 32'd1);

    ar_delay = 5;
    r_delay = 16;
    sl_rdata = 32'h12345678;
    issue(32'h80000010, 1, 32'h12345678, 1'b0, -1);
    settle();
    chk_eq("cnt_stall", fetch_cnt, 32'd2);
    chk_eq("ar_cnt_stall", 32'(ar_cnt), 32'd2);

    issue(32'h80000002, 1, 32'h0, 1'b1, 0);
    settle();
    chk_eq("cnt_misal", fetch_cnt, 32'd3);
    chk_eq("ar_cnt_misal", 32'(ar_cnt), 32'd2);

    ar_delay = 0;
    r_delay = 0;
    sl_rdata = 32'hDEADBEEF;
    sl_rresp = 2'b10;
    issue(32'h80000020, 1, 32'hDEADBEEF, 1'b1, 2);
    settle();
    chk_eq("cnt_err", fetch_cnt, 32'd4);

    ar_delay = 3;
    r_delay = 2;
    sl_rresp = 2'b00;
    sl_rdata = 32'h0BADF00D;
    issue(32'h80000030, 0, 32'h0, 1'b0, 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    settle();
    chk_eq("cnt_flush_ar", fetch_cnt, 32'd4);
    chk_eq("r_cnt_flush_ar", 32'(r_cnt), 32'd4);

    ar_delay = 0;
    r_delay = 0;
    sl_rdata = 32'h00100073;
    issue(32'h80000034, 1, 32'h00100073, 1'b0, 2);
    settle();
    chk_eq("cnt_after_flush", fetch_cnt, 32'd5);

    r_delay = 4;
    sl_rdata = 32'h0BADF00D;
    issue(32'h80000038, 0, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    settle();
    chk_eq("cnt_flush_r", fetch_cnt, 32'd5);
    chk_eq("r_cnt_flush_r", 32'(r_cnt), 32'd6);

    r_delay = 0;
    sl_rdata = 32'h00A00513;
    inst_ready = 1'b0;
    issue(32'h80000040, 1, 32'h00A00513, 1'b0, 2);
    n = 0;
    while (!inst_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(n < 100, "bp_valid_timeout", 32'(n), 32'd100);
    repeat (4) @(posedge clk);
    #1;
    inst_ready = 1'b1;
    settle();
    chk_eq("cnt_bp", fetch_cnt, 32'd6);

    do_reset();
    sl_auto = 1'b1;
    for (int i = 0; i < 8; i++)
      issue(32'h80001000 + 32'(4 * i), 1, b2b_exp[i], 1'b0, 2);
    settle();
    chk_eq("cnt_b2b", fetch_cnt, 32'd8);
    chk_eq("r_cnt_b2b", 32'(r_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
